touch_jump_decoder: RTL and testbench

//  Upstream feeder of the Nios MTL display controller. Turns raw MTL touch samples into stable per-frame

---
 rtl/mtl_touch_pkg.sv | 21 ++
 rtl/touch_quadrant_classify.sv | 46 ++++
 rtl/touch_jump_decoder.sv | 185 ++++++++++++++++++
 tb/tb_touch_jump_decoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtl_touch_pkg.sv
// Shared definitions for the MTL touch front end: jump codes, FSM states
// and the panel/game defaults used by the touch decoder.
package mtl_touch_pkg;

   localparam logic [7:0] JMP_NONE = 8'd0;
   localparam logic [7:0] JMP_UR   = 8'd1;
   localparam logic [7:0] JMP_UL   = 8'd2;
   localparam logic [7:0] JMP_DR   = 8'd3;
   localparam logic [7:0] JMP_DL   = 8'd4;

   localparam int unsigned H_RES_DEF   = 800;
   localparam int unsigned V_RES_DEF   = 480;
   localparam logic [7:0]  PLAY_STATUS = 8'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_HELD
   } touch_state_t;

endpackage

// File: rtl/touch_quadrant_classify.sv
// Combinational classifier: maps a touch coordinate to the jump code of its
// screen quadrant, or JMP_NONE when it falls in a centre dead band.
module touch_quadrant_classify
   import mtl_touch_pkg::*;
#(
   parameter int unsigned H_RES     = H_RES_DEF,
   parameter int unsigned V_RES     = V_RES_DEF,
   parameter int unsigned DEAD_ZONE = 40
) (
   input  logic [9:0] x,
   input  logic [8:0] y,
   output logic [7:0] quadrant
);

   localparam logic [10:0] X_RIGHT = 11'(H_RES / 2 + DEAD_ZONE);
   localparam logic [10:0] X_LEFT  = 11'(H_RES / 2 - DEAD_ZONE);
   localparam logic [10:0] Y_UP    = 11'(V_RES / 2 - DEAD_ZONE);
   localparam logic [10:0] Y_DOWN  = 11'(V_RES / 2 + DEAD_ZONE);

   logic [10:0] xw;
   logic [10:0] yw;
   logic        right;
   logic        left;
   logic        up;
   logic        down;

   // Widened unsigned compares against the band edges, then pick the quadrant code
   always_comb begin
      xw    = {1'b0, x};
      yw    = {2'b00, y};
      right = (xw >= X_RIGHT);
      left  = (xw <  X_LEFT);
      up    = (yw <  Y_UP);
      down  = (yw >= Y_DOWN);
      quadrant = JMP_NONE;
      if (up && right)
         quadrant = JMP_UR;
      else if (up && left)
         quadrant = JMP_UL;
      else if (down && right)
         quadrant = JMP_DR;
      else if (down && left)
         quadrant = JMP_DL;
   end

endmodule

// File: rtl/touch_jump_decoder.sv
// Touch front end for the MTL display controller: filters raw touch samples,
// latches frame-stable touch outputs on newframe, and debounces presses into
// a one-shot Q*bert jump code held for a fixed number of frames.
module touch_jump_decoder #(
   parameter int unsigned H_RES            = mtl_touch_pkg::H_RES_DEF,
   parameter int unsigned V_RES            = mtl_touch_pkg::V_RES_DEF,
   parameter int unsigned DEAD_ZONE        = 40,
   parameter int unsigned DEBOUNCE_SAMPLES = 3,
   parameter int unsigned RELEASE_TIMEOUT  = 2000000,
   parameter int unsigned JUMP_HOLD_FRAMES = 2,
   parameter logic [7:0]  PLAY_STATUS      = mtl_touch_pkg::PLAY_STATUS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       touch_valid,
   input  logic       touch_pressed,
   input  logic [9:0] touch_x,
   input  logic [8:0] touch_y,
   input  logic       newframe,
   input  logic [7:0] game_status,
   output logic       ptouch,
   output logic [9:0] xtouch,
   output logic [8:0] ytouch,
   output logic [7:0] jump
);

   import mtl_touch_pkg::*;

   touch_state_t state;
   touch_state_t state_next;

   logic        sample_ok;
   logic        press_s;
   logic        release_s;
   logic        timeout_hit;
   logic        press_done;
   logic        load_jump;
   logic [7:0]  quad;
   logic [7:0]  deb_cnt;
   logic [7:0]  deb_cnt_next;
   logic [7:0]  deb_q;
   logic [7:0]  deb_q_next;
   logic [31:0] to_cnt;
   logic        sh_p;
   logic [9:0]  sh_x;
   logic [8:0]  sh_y;
   logic [7:0]  pend;
   logic [7:0]  hold_cnt;

   touch_quadrant_classify #(
      .H_RES     (H_RES),
      .V_RES     (V_RES),
      .DEAD_ZONE (DEAD_ZONE)
   ) u_classify (
      .x        (touch_x),
      .y        (touch_y),
      .quadrant (quad)
   );

   // Sample qualification; an expiry only counts in a cycle without an accepted sample
   always_comb begin
      sample_ok   = touch_valid
                    && ({1'b0, touch_x} < 11'(H_RES))
                    && ({2'b00, touch_y} < 11'(V_RES));
      press_s     = sample_ok && touch_pressed;
      release_s   = sample_ok && !touch_pressed;
      timeout_hit = (state != ST_IDLE) && !sample_ok && (to_cnt >= RELEASE_TIMEOUT);
      load_jump   = newframe && (hold_cnt <= 8'd1) && (pend != JMP_NONE);
   end

   // Debounce FSM next-state; completion is detected on the updated count so
   // DEBOUNCE_SAMPLES=1 completes straight out of IDLE
   always_comb begin
      state_next   = state;
      deb_cnt_next = deb_cnt;
      deb_q_next   = deb_q;
      press_done   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (press_s && quad != JMP_NONE) begin
               deb_cnt_next = 8'd1;
               deb_q_next   = quad;
               state_next   = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (release_s || timeout_hit) begin
               state_next = ST_IDLE;
            end else if (press_s) begin
               if (quad == JMP_NONE) begin
                  deb_cnt_next = '0;
               end else if (quad == deb_q) begin
                  deb_cnt_next = deb_cnt + 8'd1;
               end else begin
                  deb_cnt_next = 8'd1;
                  deb_q_next   = quad;
               end
            end
         end
         ST_HELD: begin
            if (release_s || timeout_hit)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (state_next == ST_DEBOUNCE && deb_cnt_next == 8'(DEBOUNCE_SAMPLES)) begin
         press_done = 1'b1;
         state_next = ST_HELD;
      end
   end

   // FSM state, debounce count and candidate quadrant registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         deb_cnt <= '0;
         deb_q   <= JMP_NONE;
      end else begin
         state   <= state_next;
         deb_cnt <= deb_cnt_next;
         deb_q   <= deb_q_next;
      end
   end

   // Release timeout: cleared by pressed samples, runs only while a press is tracked
   always_ff @(posedge clk) begin
      if (reset || state == ST_IDLE || press_s)
         to_cnt <= '0;
      else if (to_cnt < RELEASE_TIMEOUT)
         to_cnt <= to_cnt + 32'd1;
   end

   // Shadow registers capture every accepted sample
   always_ff @(posedge clk) begin
      if (reset) begin
         sh_p <= 1'b0;
         sh_x <= '0;
         sh_y <= '0;
      end else if (sample_ok) begin
         sh_p <= touch_pressed;
         sh_x <= touch_x;
         sh_y <= touch_y;
      end
   end

   // Frame latch: outputs move only on newframe, taking the pre-edge shadows
   always_ff @(posedge clk) begin
      if (reset) begin
         ptouch <= 1'b0;
         xtouch <= '0;
         ytouch <= '0;
      end else if (newframe) begin
         ptouch <= sh_p;
         xtouch <= sh_x;
         ytouch <= sh_y;
      end
   end

   // Jump hold: a pending code loads on the newframe that ends the previous hold;
   // a completion in the same cycle as that load overwrites pend for the next one
   always_ff @(posedge clk) begin
      if (reset) begin
         pend     <= JMP_NONE;
         hold_cnt <= '0;
         jump     <= JMP_NONE;
      end else begin
         if (newframe) begin
            if (hold_cnt > 8'd1) begin
               hold_cnt <= hold_cnt - 8'd1;
            end else if (pend != JMP_NONE) begin
               jump     <= pend;
               hold_cnt <= 8'(JUMP_HOLD_FRAMES);
            end else begin
               jump     <= JMP_NONE;
               hold_cnt <= '0;
            end
         end
         if (press_done && game_status == PLAY_STATUS)
            pend <= deb_q_next;
         else if (load_jump)
            pend <= JMP_NONE;
      end
   end

endmodule

// File: tb/tb_touch_jump_decoder.sv
// Self-checking bench for touch_jump_decoder: directed vector table, hand-written
// reset/timeout sequences and a randomized run against a behavioural model.
module tb_touch_jump_decoder;

   localparam int unsigned T_OUT = 50;
   localparam int unsigned JHF   = 2;
   localparam int unsigned DS    = 3;
   localparam int          CX    = 400;
   localparam int          CY    = 240;
   localparam int          DZ    = 40;

   logic       clk = 1'b0;
   logic       reset;
   logic       touch_valid;
   logic       touch_pressed;
   logic [9:0] touch_x;
   logic [8:0] touch_y;
   logic       newframe;
   logic [7:0] game_status;
   logic       ptouch;
   logic [9:0] xtouch;
   logic [8:0] ytouch;
   logic [7:0] jump;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic v; logic p; int x; int y; logic nf; int st;
      int ep; int ex; int ey; int ej;
   } vec_t;
   vec_t tbl[$];

   // model state
   int m_sh_p, m_sh_x, m_sh_y, m_p, m_x, m_y;
   int m_jump, m_pend, m_frame, m_until;
   int m_down, m_fired, m_run, m_runq, m_last_press;

   always #5 clk = ~clk;

   touch_jump_decoder #(
      .H_RES            (800),
      .V_RES            (480),
      .DEAD_ZONE        (40),
      .DEBOUNCE_SAMPLES (DS),
      .RELEASE_TIMEOUT  (T_OUT),
      .JUMP_HOLD_FRAMES (JHF),
      .PLAY_STATUS      (8'd1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .touch_valid   (touch_valid),
      .touch_pressed (touch_pressed),
      .touch_x       (touch_x),
      .touch_y       (touch_y),
      .newframe      (newframe),
      .game_status   (game_status),
      .ptouch        (ptouch),
      .xtouch        (xtouch),
      .ytouch        (ytouch),
      .jump          (jump)
   );

   function automatic logic [27:0] pack(input int p, input int x, input int y, input int j);
      return {p[0], x[9:0], y[8:0], j[7:0]};
   endfunction

   function automatic logic [27:0] outs();
      return {ptouch, xtouch, ytouch, jump};
   endfunction

   task automatic drive(input logic v, input logic p, input int x, input int y,
                        input logic nf, input int st);
      touch_valid   = v;
      touch_pressed = p;
      touch_x       = 10'(x);
      touch_y       = 9'(y);
      newframe      = nf;
      game_status   = 8'(st);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1);
   endtask

   task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got p=%0d x=%0d y=%0d jump=%0d, expected p=%0d x=%0d y=%0d jump=%0d",
                  name, got[27], got[26:17], got[16:8], got[7:0],
                  exp[27], exp[26:17], exp[16:8], exp[7:0]);
      end
   endtask

   function automatic void add(input logic v, input logic p, input int x, input int y,
                               input logic nf, input int st,
                               input int ep, input int ex, input int ey, input int ej);
      tbl.push_back('{v, p, x, y, nf, st, ep, ex, ey, ej});
   endfunction

   function automatic int m_quad(input int x, input int y);
      bit r, l, u, d;
      r = (x >= CX + DZ);
      l = (x <  CX - DZ);
      u = (y <  CY - DZ);
      d = (y >= CY + DZ);
      if (u && r) return 1;
      if (u && l) return 2;
      if (d && r) return 3;
      if (d && l) return 4;
      return 0;
   endfunction

   function automatic void m_reset();
      m_sh_p = 0; m_sh_x = 0; m_sh_y = 0; m_p = 0; m_x = 0; m_y = 0;
      m_jump = 0; m_pend = 0; m_frame = 0; m_until = 0;
      m_down = 0; m_fired = 0; m_run = 0; m_runq = 0; m_last_press = -100000;
   endfunction

   // One clock edge of the reference: frame effects use pre-edge state, then the sample
   function automatic void m_step(input int c, input bit v, input bit p, input int x,
                                  input int y, input bit nf, input int st);
      int q;
      if (nf) begin
         m_p = m_sh_p; m_x = m_sh_x; m_y = m_sh_y;
         m_frame++;
         if (m_jump != 0 && m_frame == m_until) m_jump = 0;
         if (m_jump == 0 && m_pend != 0) begin
            m_jump  = m_pend;
            m_pend  = 0;
            m_until = m_frame + JHF;
         end
      end
      if (v && x < 800 && y < 480) begin
         m_sh_p = p; m_sh_x = x; m_sh_y = y;
         if (m_down && (c - m_last_press) > int'(T_OUT) + 1) begin
            m_down = 0; m_fired = 0; m_run = 0;
         end
         if (!p) begin
            m_down = 0; m_fired = 0; m_run = 0;
         end else begin
            q = m_quad(x, y);
            m_last_press = c;
            if (!m_down) begin
               if (q != 0) begin m_down = 1; m_run = 1; m_runq = q; end
            end else if (!m_fired) begin
               if (q == 0)          m_run = 0;
               else if (q == m_runq) m_run++;
               else begin m_run = 1; m_runq = q; end
            end
            if (m_down && !m_fired && m_run == int'(DS)) begin
               m_fired = 1;
               if (st == 1) m_pend = m_runq;
            end
         end
      end
   endfunction

   initial begin
      int next_s, gen_last, since, px, py, x, y, st;
      bit v, p, nf;

      reset = 1'b1;
      idle(2);
      check("reset_state", outs(), pack(0, 0, 0, 0));
      reset = 1'b0;

      // directed table: basic jump, quadrant switch, dead band, discards, status gate
      for (int i = 0; i < 3; i++) add(1, 1, 700, 100, 0, 1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 1, 1, 700, 100, 1);
      add(0, 0, 0, 0, 0, 1, 1, 700, 100, 1);
      add(0, 0, 0, 0, 1, 1, 1, 700, 100, 1);
      add(0, 0, 0, 0, 1, 1, 1, 700, 100, 0);
      add(1, 0, 700, 100, 0, 1, 1, 700, 100, 0);
      add(0, 0, 0, 0, 1, 1, 0, 700, 100, 0);
      add(1, 1, 700, 100, 0, 1, 0, 700, 100, 0);
      add(1, 1, 100, 100, 0, 1, 0, 700, 100, 0);
      add(1, 1, 100, 100, 0, 1, 0, 700, 100, 0);
      add(1, 1, 100, 100, 1, 1, 1, 100, 100, 0);
      add(0, 0, 0, 0, 1, 1, 1, 100, 100, 2);
      add(0, 0, 0, 0, 1, 1, 1, 100, 100, 2);
      add(0, 0, 0, 0, 1, 1, 1, 100, 100, 0);
      add(1, 0, 100, 100, 0, 1, 1, 100, 100, 0);
      for (int i = 0; i < 5; i++) add(1, 1, 400, 100, 0, 1, 1, 100, 100, 0);
      add(0, 0, 0, 0, 1, 1, 1, 400, 100, 0);
      add(0, 0, 0, 0, 1, 1, 1, 400, 100, 0);
      add(1, 1, 700, 100, 0, 1, 1, 400, 100, 0);
      add(1, 1, 700, 100, 0, 1, 1, 400, 100, 0);
      add(1, 1, 900, 100, 0, 1, 1, 400, 100, 0);
      add(1, 1, 10, 500, 0, 1, 1, 400, 100, 0);
      add(0, 0, 0, 0, 1, 1, 1, 700, 100, 0);
      add(1, 1, 700, 100, 0, 1, 1, 700, 100, 0);
      add(0, 0, 0, 0, 1, 1, 1, 700, 100, 1);
      add(0, 0, 0, 0, 1, 1, 1, 700, 100, 1);
      add(0, 0, 0, 0, 1, 1, 1, 700, 100, 0);
      add(1, 0, 700, 100, 0, 1, 1, 700, 100, 0);
      for (int i = 0; i < 3; i++) add(1, 1, 100, 400, 0, 0, 1, 700, 100, 0);
      add(0, 0, 0, 0, 1, 0, 1, 100, 400, 0);
      add(0, 0, 0, 0, 1, 0, 1, 100, 400, 0);
      add(1, 0, 100, 400, 0, 0, 1, 100, 400, 0);
      add(0, 0, 0, 0, 1, 0, 0, 100, 400, 0);
      add(1, 1, 500, 300, 1, 1, 0, 100, 400, 0);
      add(1, 0, 500, 300, 0, 1, 0, 100, 400, 0);
      add(0, 0, 0, 0, 1, 1, 0, 500, 300, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].p, tbl[i].x, tbl[i].y, tbl[i].nf, tbl[i].st);
         check($sformatf("vec%0d", i), outs(),
               pack(tbl[i].ep, tbl[i].ex, tbl[i].ey, tbl[i].ej));
      end

      // reset in the middle of a held press with a jump showing
      for (int i = 0; i < 3; i++) drive(1, 1, 700, 100, 0, 1);
      drive(0, 0, 0, 0, 1, 1);
      check("held_jump", outs(), pack(1, 700, 100, 1));
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 1);
      check("reset_mid_held", outs(), pack(0, 0, 0, 0));
      reset = 1'b0;
      drive(1, 1, 700, 100, 0, 1);
      drive(1, 1, 700, 100, 0, 1);
      drive(0, 0, 0, 0, 1, 1);
      check("restart_partial", outs(), pack(1, 700, 100, 0));
      drive(1, 1, 700, 100, 0, 1);
      drive(0, 0, 0, 0, 1, 1);
      check("restart_jump", outs(), pack(1, 700, 100, 1));
      drive(0, 0, 0, 0, 1, 1);
      drive(0, 0, 0, 0, 1, 1);
      check("restart_clear", outs(), pack(1, 700, 100, 0));

      // held press ignores new quadrants until the timeout forces a release
      for (int i = 0; i < 3; i++) drive(1, 1, 100, 100, 0, 1);
      drive(0, 0, 0, 0, 1, 1);
      check("held_ignores", outs(), pack(1, 100, 100, 0));
      idle(T_OUT + 20);
      for (int i = 0; i < 3; i++) drive(1, 1, 100, 100, 0, 1);
      drive(0, 0, 0, 0, 1, 1);
      check("after_timeout", outs(), pack(1, 100, 100, 2));

      // randomized run against the reference model
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      m_reset();
      next_s = 0; gen_last = -100000; px = 700; py = 100;
      for (int c = 0; c < 4000; c++) begin
         v = 0; p = 0; x = 0; y = 0;
         if (c == next_s) begin
            v = 1;
            p = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 8) begin
               if ($urandom_range(0, 1) == 0) begin
                  x = $urandom_range(800, 1023); y = $urandom_range(0, 511);
               end else begin
                  x = $urandom_range(0, 1023); y = $urandom_range(480, 511);
               end
            end else begin
               if ($urandom_range(0, 99) >= 60) begin
                  case ($urandom_range(0, 3))
                     0: px = 100;
                     1: px = 700;
                     2: px = 400;
                     default: px = $urandom_range(0, 799);
                  endcase
                  case ($urandom_range(0, 3))
                     0: py = 100;
                     1: py = 400;
                     2: py = 240;
                     default: py = $urandom_range(0, 479);
                  endcase
               end
               x = px; y = py;
               if (p) gen_last = c;
            end
            next_s = c + 1 + $urandom_range(0, 3);
            if ($urandom_range(0, 39) == 0) next_s = c + int'(T_OUT) + 20;
            since = next_s - gen_last;
            if (since >= int'(T_OUT) - 4 && since <= int'(T_OUT) + 6) next_s += 15;
         end
         nf = ($urandom_range(0, 5) == 0);
         st = ($urandom_range(0, 9) < 8) ? 1 : $urandom_range(0, 3);
         drive(v, p, x, y, nf, st);
         m_step(c, v, p, x, y, nf, st);
         check($sformatf("rand_c%0d", c), outs(), pack(m_p, m_x, m_y, m_jump));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
